// File: rtl/rv32i_mc_core.sv
// rv32i_mc_core: multi-cycle RV32I/RV32E core with req/ack instruction and data memory ports
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req/addr/rdata/ack   instruction fetch handshake, imem_addr == pc
//   dmem_req/we/addr/wdata/wstrb/rdata/ack  data handshake, word-aligned address, byte strobes
//   pc                        address of the current instruction
//   halted                    sticky trap indicator, cleared only by rst
module rv32i_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] pc,
  output logic        halted
);
  localparam int AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
    OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  typedef enum logic [1:0] {FETCH, EXEC, MEM, TRAP} state_t;
  state_t state, state_n;
  logic [31:0] ir;
  logic [1:0]  ea_lo;
  logic [31:0] rf [NREGS];
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic        is_r, is_i, is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_mem;
  logic        use_rd, use_rs1, use_rs2, known, bad_rd, bad_rs1, bad_rs2;
  logic [31:0] rv1, rv2, alu_b, alu_y, pc4, target, next_pc, ea_n, wb_val, lane, ld_val;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [4:0]  sh;
  logic        take, redirect, br_ok, ld_ok, st_ok, misal, trap, wb_en, rf_we;
  assign op  = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign i_imm = {{20{ir[31]}}, ir[31:20]};
  assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign u_imm = {ir[31:12], 12'b0};
  assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign is_r     = op == OP_R;
  assign is_i     = op == OP_I;
  assign is_lui   = op == OP_LUI;
  assign is_auipc = op == OP_AUIPC;
  assign is_jal   = op == OP_JAL;
  assign is_jalr  = op == OP_JALR;
  assign is_br    = op == OP_BR;
  assign is_ld    = op == OP_LD;
  assign is_st    = op == OP_ST;
  assign is_mem   = is_ld | is_st;
  assign use_rd  = is_r | is_i | is_lui | is_auipc | is_jal | is_jalr | is_ld;
  assign use_rs1 = is_r | is_i | is_jalr | is_br | is_ld | is_st;
  assign use_rs2 = is_r | is_br | is_st;
  assign known   = use_rd | is_br | is_st;
  assign bad_rd  = {1'b0, rd} >= NR;
  assign bad_rs1 = {1'b0, rs1} >= NR;
  assign bad_rs2 = {1'b0, rs2} >= NR;
  assign rv1 = (rs1 == 5'd0 || bad_rs1) ? 32'd0 : rf[rs1[AW-1:0]];
  assign rv2 = (rs2 == 5'd0 || bad_rs2) ? 32'd0 : rf[rs2[AW-1:0]];
  assign imem_addr = pc;
  assign halted    = state == TRAP;
  always_comb begin
    alu_b = is_r ? rv2 : i_imm;
    sh = alu_b[4:0];
    alu_y = f3 == 3'b000 ? ((is_r && ir[30]) ? rv1 - alu_b : rv1 + alu_b) :
            f3 == 3'b001 ? rv1 << sh :
            f3 == 3'b010 ? {31'b0, $signed(rv1) < $signed(alu_b)} :
            f3 == 3'b011 ? {31'b0, rv1 < alu_b} :
            f3 == 3'b100 ? rv1 ^ alu_b :
            f3 == 3'b101 ? (ir[30] ? 32'($signed(rv1) >>> sh) : rv1 >> sh) :
            f3 == 3'b110 ? rv1 | alu_b : rv1 & alu_b;
    br_ok = f3[2:1] != 2'b01;
    take = f3[2:1] == 2'b00 ? ((rv1 == rv2) ^ f3[0]) :
           f3[2:1] == 2'b10 ? (($signed(rv1) < $signed(rv2)) ^ f3[0]) :
                              ((rv1 < rv2) ^ f3[0]);
    pc4 = pc + 32'd4;
    target = is_jal ? pc + j_imm : is_jalr ? (rv1 + i_imm) & ~32'd1 : pc + b_imm;
    redirect = is_jal | is_jalr | (is_br & take);
    next_pc = redirect ? target : pc4;
    ea_n = rv1 + (is_st ? s_imm : i_imm);
    ld_ok = !(f3 == 3'b011 || f3[2:1] == 2'b11);
    st_ok = !f3[2] && f3[1:0] != 2'b11;
    misal = (f3[1:0] == 2'b01 && ea_n[0]) || (f3[1:0] == 2'b10 && ea_n[1:0] != 2'b00);
    trap = !known || (is_ld && (!ld_ok || misal)) || (is_st && (!st_ok || misal)) ||
           (is_br && !br_ok) || (redirect && target[1:0] != 2'b00) ||
           (use_rd && bad_rd) || (use_rs1 && bad_rs1) || (use_rs2 && bad_rs2);
    wb_val = is_lui ? u_imm : is_auipc ? pc + u_imm : (is_jal | is_jalr) ? pc4 : alu_y;
    st_strb = f3[1:0] == 2'b00 ? 4'b0001 << ea_n[1:0] :
              f3[1:0] == 2'b01 ? (ea_n[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_data = f3[1:0] == 2'b00 ? {4{rv2[7:0]}} : f3[1:0] == 2'b01 ? {2{rv2[15:0]}} : rv2;
    lane = dmem_rdata >> {ea_lo, 3'b000};
    ld_val = f3 == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
             f3 == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
             f3 == 3'b100 ? {24'b0, lane[7:0]} :
             f3 == 3'b101 ? {16'b0, lane[15:0]} : lane;
    wb_en = state == EXEC && !trap && use_rd && !is_ld;
    rf_we = (wb_en || (state == MEM && dmem_ack && !dmem_we)) && rd != 5'd0;
  end
  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    case (state)
      FETCH: begin
        imem_req = !rst;
        state_n  = imem_ack ? EXEC : FETCH;
      end
      EXEC: state_n = trap ? TRAP : is_mem ? MEM : FETCH;
      MEM: begin
        dmem_req = 1'b1;
        state_n  = dmem_ack ? FETCH : MEM;
      end
      default: state_n = TRAP;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      ir         <= 32'd0;
      ea_lo      <= 2'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_wstrb <= 4'd0;
    end else begin
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      if (state == EXEC && !trap && is_mem) begin
        ea_lo      <= ea_n[1:0];
        dmem_we    <= is_st;
        dmem_addr  <= {ea_n[31:2], 2'b00};
        dmem_wdata <= is_st ? st_data : 32'd0;
        dmem_wstrb <= is_st ? st_strb : 4'd0;
      end
      if (state == EXEC && !trap && !is_mem) pc <= next_pc;
      if (state == MEM && dmem_ack) pc <= pc4;
    end
  end
  always_ff @(posedge clk)
    if (rf_we) rf[rd[AW-1:0]] <= state == MEM ? ld_val : wb_val;
endmodule

// File: doc/rv32i_mc_core.md
Name: rv32i_mc_core

Overview:
Multi-cycle RV32I integer core, successor to the single-cycle core. It uses byte-addressed PC, a synchronous register file and an explicit FSM. Instruction and data memories sit behind req/ack handshakes, so wait-state memories attach directly. Sub-word stores use byte strobes. The register file is parametrised so the same RTL builds RV32E. Illegal and misaligned operations stop the core in a sticky halt state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
NREGS, 32, architectural register count; legal values are 32 (RV32I) and 16 (RV32E).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request; held high until imem_ack.
imem_addr  out  32  fetch address; always equals pc.
imem_rdata  in  32  instruction word; valid when imem_ack=1.
imem_ack  in  1  fetch complete; may be high in the same cycle as imem_req.
dmem_req  out  1  data access request; held high until dmem_ack.
dmem_we  out  1  1 = store, 0 = load.
dmem_addr  out  32  word-aligned address {ea[31:2],2'b00}.
dmem_wdata  out  32  store data, lane-replicated.
dmem_wstrb  out  4  byte enables; 4'b0000 on loads.
dmem_rdata  in  32  load data word; valid when dmem_ack=1.
dmem_ack  in  1  data access complete.
pc  out  32  address of the current instruction.
halted  out  1  sticky trap indicator.

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC; state=FETCH; halted=0; imem_req=0; dmem_req=0; dmem_we=0; dmem_wstrb=0; dmem_addr=0; dmem_wdata=0. Register file contents are not reset. x0 reads 0 always; writes to x0 are dropped.
- States: FETCH, EXEC, MEM, TRAP.
- FETCH:
  - imem_req=1.
  - On an edge with imem_ack=1: latch imem_rdata into ir; go to EXEC.
  - Minimum fetch time is one cycle.
- EXEC (one cycle):
  - Decode ir, read rs1/rs2, compute.
  - ALU-reg, ALU-imm, LUI, AUIPC, JAL, JALR, branch: write rd and update pc on this edge, then go to FETCH.
  - Load/store: register the effective address ea=rs1+imm (I-imm for loads, S-imm for stores), set up dmem outputs, go to MEM.
- MEM:
  - dmem_req=1.
  - On an edge with dmem_ack=1: loads write rd; pc+=4; go to FETCH; dmem_req drops the next cycle.
- CPI: 2 for ALU/branch/jump and 3 for load/store, with zero-wait memories.
- ALU:
  - SUB and SRA only for opcode 0110011 with funct7[5]=1. ADDI is never subtract.
  - SRAI/SRLI are selected by ir[30].
  - Shift amount is 5 bits.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned, with the sign-extended immediate treated as unsigned.
- Branches:
  - BEQ/BNE equality; BLT/BGE signed; BLTU/BGEU unsigned.
  - Taken: pc+=B-imm. Not taken: pc+=4.
- Jumps:
  - JAL: rd=pc+4; pc+=J-imm.
  - JALR: rd=pc+4; pc=(rs1+I-imm)&~1. Compute using the old rs1 when rd==rs1.
- Immediates:
  - AUIPC: rd=pc+U-imm.
  - All immediates are sign-extended from ir[31].
- Stores:
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<ea[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=ea[1]?4'b1100:4'b0011.
  - SW: wdata=rs2, wstrb=4'b1111.
- Loads:
  - Byte lane is dmem_rdata>>(8*ea[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- Traps (go to TRAP, no architectural side effects, no memory request issued):
  - Unknown opcode.
  - Unknown funct3 for load, store or branch.
  - Register index >= NREGS.
  - Misaligned LH/LHU/SH (ea[0]=1) or LW/SW (ea[1:0]!=0).
  - Taken branch or jump target with target[1:0]!=0.
- TRAP: halted=1; all requests 0; pc holds the faulting instruction's address. Only rst exits.
- Outputs are stable while a request is pending. The core never withdraws a request before its ack.
- Ack is ignored when req=0. A spurious imem_ack in EXEC or MEM has no effect.
- Reset during MEM drops dmem_req asynchronously. The memory must tolerate the abandoned request.
- Wrap-around: pc+4 and address sums are modulo 2^32.

Test Plan:
- Reset with RESET_PC=32'h100 → imem_req=1, imem_addr=32'h100, halted=0.
- ADDI x1,x0,-5; SLTIU x2,x1,1; SRAI x3,x1,1; zero-wait memory → x1=FFFFFFFB, x2=0, x3=FFFFFFFD, 2 cycles per instruction.
- x1=-1, x2=1; BLT x1,x2,+8 then BLTU x1,x2,+8 → first taken (pc+8), second not taken (pc+4).
- SH x5=0x0000ABCD to ea=0x202 → dmem_addr=0x200, wstrb=1100, wdata=ABCDABCD. LB from 0x203 with rdata=0x80FF_0000 → rd=FFFFFF80. With 3 ack wait-states, dmem_req is held for 4 cycles.
- Opcode 7'b1111111, then LW from ea=0x102 → each case: halted=1, pc unchanged, no dmem_req. With NREGS=16, ADD x20,... → halted=1.
- Assert rst during MEM with ack withheld → dmem_req drops the same cycle, pc=RESET_PC. Normal fetch resumes after release.
